div_len_prep: RTL and testbench

Front-end stage that sits directly upstream of the `div` divider. It accepts raw 32-bit dividend/divisor pairs over a valid/ready handshake and computes each operand's significant bit length. It then presents operands plus lengths to `div`, pulses `inpt_sgnl` for one cycle, and holds off new work until `div` raises `done`. It also traps divide-by-zero so the divider is never started on a zero divisor.

---
 rtl/div_pkg.sv | 16 +
 rtl/msb_len.sv | 17 +
 rtl/div_len_prep.sv | 139 +++++++++++++
 tb/tb_div_len_prep.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and types for the divider front-end and the div core.
package div_pkg;

  localparam int unsigned W     = 32;
  localparam int unsigned LEN_W = 7;

  typedef logic signed [LEN_W-1:0] len_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ISSUE,
    ST_WAIT
  } state_e;

endpackage

// File: rtl/msb_len.sv
// Leading-one length encoder: index of the highest set bit plus one, zero for a zero input.
module msb_len #(
  parameter int unsigned W     = div_pkg::W,
  parameter int unsigned LEN_W = div_pkg::LEN_W
) (
  input  logic [W-1:0]     val_i,
  output logic [LEN_W-1:0] len_c
);

  always_comb begin
    len_c = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (val_i[i]) len_c = LEN_W'(i + 1);
    end
  end

endmodule

// File: rtl/div_len_prep.sv
// Front-end for div: captures an operand pair, measures both bit lengths, starts div and waits for done.
// Define DIV_LEN_PREP_FAST_SCAN_EN for a one-cycle leading-one encoder instead of the 32-cycle serial scan.
module div_len_prep #(
  parameter int unsigned W     = div_pkg::W,
  parameter int unsigned LEN_W = div_pkg::LEN_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W-1:0]            in_dvdnd,
  input  logic [W-1:0]            in_dvsr,
  output logic [W-1:0]            dvdnd,
  output logic [W-1:0]            dvsr,
  output logic signed [LEN_W-1:0] dvdnd_len,
  output logic signed [LEN_W-1:0] dvsr_len,
  output logic                    inpt_sgnl,
  input  logic                    done,
  output logic                    err_div0,
  output logic                    busy
);
  import div_pkg::*;

  state_e           state_q;
  logic [W-1:0]     cap_dvdnd_q;
  logic [W-1:0]     cap_dvsr_q;
  logic             seen_low_q;
  logic [LEN_W-1:0] scan_len_a;
  logic [LEN_W-1:0] scan_len_b;
  logic             scan_last;

`ifdef DIV_LEN_PREP_FAST_SCAN_EN
  msb_len #(.W(W), .LEN_W(LEN_W)) u_len_dvdnd (.val_i(cap_dvdnd_q), .len_c(scan_len_a));
  msb_len #(.W(W), .LEN_W(LEN_W)) u_len_dvsr  (.val_i(cap_dvsr_q),  .len_c(scan_len_b));

  assign scan_last = 1'b1;
`else
  logic [W-1:0]     sh_dvdnd_q;
  logic [W-1:0]     sh_dvsr_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] len_a_q;
  logic [LEN_W-1:0] len_b_q;

  // A length latches the down-counter on the first cycle its shifted copy shows a 1 in the MSB.
  always_comb begin
    scan_len_a = len_a_q;
    scan_len_b = len_b_q;
    if (len_a_q == '0 && sh_dvdnd_q[W-1]) scan_len_a = cnt_q;
    if (len_b_q == '0 && sh_dvsr_q[W-1])  scan_len_b = cnt_q;
  end

  assign scan_last = (cnt_q == LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_dvdnd_q <= '0;
      sh_dvsr_q  <= '0;
      cnt_q      <= '0;
      len_a_q    <= '0;
      len_b_q    <= '0;
    end else if (state_q == ST_IDLE && in_valid) begin
      sh_dvdnd_q <= in_dvdnd;
      sh_dvsr_q  <= in_dvsr;
      cnt_q      <= LEN_W'(W);
      len_a_q    <= '0;
      len_b_q    <= '0;
    end else if (state_q == ST_SCAN) begin
      sh_dvdnd_q <= sh_dvdnd_q << 1;
      sh_dvsr_q  <= sh_dvsr_q << 1;
      cnt_q      <= cnt_q - LEN_W'(1);
      len_a_q    <= scan_len_a;
      len_b_q    <= scan_len_b;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cap_dvdnd_q <= '0;
      cap_dvsr_q  <= '0;
      seen_low_q  <= 1'b0;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
      inpt_sgnl   <= 1'b0;
      err_div0    <= 1'b0;
      dvdnd       <= '0;
      dvsr        <= '0;
      dvdnd_len   <= '0;
      dvsr_len    <= '0;
    end else begin
      inpt_sgnl <= 1'b0;
      err_div0  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            cap_dvdnd_q <= in_dvdnd;
            cap_dvsr_q  <= in_dvsr;
            seen_low_q  <= 1'b0;
            err_div0    <= (in_dvsr == '0);
            in_ready    <= 1'b0;
            busy        <= 1'b1;
            state_q     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // A zero divisor never reaches div.
          if (cap_dvsr_q == '0) begin
            in_ready <= 1'b1;
            busy     <= 1'b0;
            state_q  <= ST_IDLE;
          end else if (scan_last) begin
            dvdnd     <= cap_dvdnd_q;
            dvsr      <= cap_dvsr_q;
            dvdnd_len <= scan_len_a;
            dvsr_len  <= scan_len_b;
            inpt_sgnl <= 1'b1;
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // A short dividend finishes in div at once, so no low phase of done is expected.
          if (done && (seen_low_q || dvdnd_len < dvsr_len)) begin
            in_ready <= 1'b1;
            busy     <= 1'b0;
            state_q  <= ST_IDLE;
          end else if (!done) begin
            seen_low_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_len_prep.sv
// Bench for div_len_prep: timeline model of the handshake checked every cycle, directed cases, random traffic.
module tb_div_len_prep;

  localparam int unsigned W     = 32;
  localparam int unsigned LEN_W = 7;
`ifdef DIV_LEN_PREP_FAST_SCAN_EN
  localparam int SCAN_CYC = 1;
`else
  localparam int SCAN_CYC = 32;
`endif
  localparam int ISSUE_CYC = SCAN_CYC + 1;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    done = 1'b1;
  logic [W-1:0]            in_dvdnd = '0;
  logic [W-1:0]            in_dvsr = '0;
  logic                    in_ready;
  logic                    inpt_sgnl;
  logic                    err_div0;
  logic                    busy;
  logic [W-1:0]            dvdnd;
  logic [W-1:0]            dvsr;
  logic signed [LEN_W-1:0] dvdnd_len;
  logic signed [LEN_W-1:0] dvsr_len;

  int n_chk = 0;
  int n_fail = 0;

  div_len_prep dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dvdnd  (in_dvdnd),
    .in_dvsr   (in_dvsr),
    .dvdnd     (dvdnd),
    .dvsr      (dvsr),
    .dvdnd_len (dvdnd_len),
    .dvsr_len  (dvsr_len),
    .inpt_sgnl (inpt_sgnl),
    .done      (done),
    .err_div0  (err_div0),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int bit_len(input logic [W-1:0] v);
    int n;
    n = 0;
    while (v != '0) begin
      v = v >> 1;
      n++;
    end
    return n;
  endfunction

  // Model: position in a transaction is counted in edges since acceptance.
  bit           m_busy = 1'b0;
  bit           m_div0 = 1'b0;
  bit           m_seen_low = 1'b0;
  bit           m_pulse = 1'b0;
  bit           m_err = 1'b0;
  int           m_age = 0;
  int           m_la = 0;
  int           m_lb = 0;
  int           e_la = 0;
  int           e_lb = 0;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  logic [W-1:0] e_a = '0;
  logic [W-1:0] e_b = '0;

  always @(posedge clk) begin
    m_pulse = 1'b0;
    m_err   = 1'b0;
    if (rst) begin
      m_busy = 1'b0;
      e_a = '0; e_b = '0; e_la = 0; e_lb = 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy     = 1'b1;
        m_a        = in_dvdnd;
        m_b        = in_dvsr;
        m_la       = bit_len(in_dvdnd);
        m_lb       = bit_len(in_dvsr);
        m_div0     = (in_dvsr == '0);
        m_err      = m_div0;
        m_seen_low = 1'b0;
        m_age      = 0;
      end
    end else begin
      m_age++;
      if (m_div0) begin
        m_busy = 1'b0;
      end else if (m_age == SCAN_CYC) begin
        e_a = m_a; e_b = m_b; e_la = m_la; e_lb = m_lb;
        m_pulse = 1'b1;
      end else if (m_age > ISSUE_CYC) begin
        if (done && (m_seen_low || m_la < m_lb)) m_busy = 1'b0;
        else if (!done) m_seen_low = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("in_ready",  64'(in_ready),  64'(!m_busy));
    check("busy",      64'(busy),      64'(m_busy));
    check("inpt_sgnl", 64'(inpt_sgnl), 64'(m_pulse));
    check("err_div0",  64'(err_div0),  64'(m_err));
    check("dvdnd",     64'(dvdnd),     64'(e_a));
    check("dvsr",      64'(dvsr),      64'(e_b));
    check("dvdnd_len", 64'(dvdnd_len), 64'(e_la));
    check("dvsr_len",  64'(dvsr_len),  64'(e_lb));
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 64'(in_ready), 64'(1));
  endtask

  // Issue one pair, then shape done in WAIT: hi_cyc cycles high, lo_cyc cycles low, then high.
  task automatic do_pair(input logic [W-1:0] a, input logic [W-1:0] b, input int xla, input int xlb,
                         input int hi_cyc, input int lo_cyc, input bit hold);
    int n;
    done = 1'b1;
    wait_ready();
    in_valid = 1'b1; in_dvdnd = a; in_dvsr = b;
    @(negedge clk);
    n = 1;
    if (!hold) in_valid = 1'b0;
    while (!inpt_sgnl && n < 100) begin
      if (hold) begin in_dvdnd = $urandom; in_dvsr = $urandom; end
      @(negedge clk);
      n++;
    end
    check("issue_cycle", 64'(n), 64'(ISSUE_CYC));
    check("issue_dvdnd", 64'(dvdnd), 64'(a));
    check("issue_dvsr", 64'(dvsr), 64'(b));
    check("issue_dvdnd_len", 64'(dvdnd_len), 64'(xla));
    check("issue_dvsr_len", 64'(dvsr_len), 64'(xlb));
    @(negedge clk);
    for (int i = 0; i < hi_cyc; i++) begin
      done = 1'b1;
      if (hold) begin in_dvdnd = $urandom; in_dvsr = $urandom; end
      @(negedge clk);
    end
    for (int i = 0; i < lo_cyc; i++) begin
      done = 1'b0;
      if (hold) begin in_dvdnd = $urandom; in_dvsr = $urandom; end
      @(negedge clk);
    end
    check("hold_in_wait", 64'(in_ready), 64'(0));
    done = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("ready_after_done", 64'(in_ready), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_dvdnd_len", 64'(dvdnd_len), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    do_pair(32'd222, 32'd20, 8, 5, 1, 2, 1'b0);
    do_pair(32'd1, 32'd100, 1, 7, 0, 0, 1'b0);
    do_pair(32'd0, 32'd5, 0, 3, 0, 1, 1'b0);
    do_pair(32'hFFFF_FFFF, 32'd1, 32, 1, 0, 3, 1'b0);

    // Zero divisor: error pulse in cycle 1, ready again in cycle 2.
    wait_ready();
    in_valid = 1'b1; in_dvdnd = 32'd15; in_dvsr = 32'd0;
    @(negedge clk);
    in_valid = 1'b0;
    check("div0_err", 64'(err_div0), 64'(1));
    check("div0_not_ready", 64'(in_ready), 64'(0));
    check("div0_no_start", 64'(inpt_sgnl), 64'(0));
    @(negedge clk);
    check("div0_ready", 64'(in_ready), 64'(1));
    check("div0_err_clear", 64'(err_div0), 64'(0));
    do_pair(32'h0000_1000, 32'd3, 13, 2, 2, 1, 1'b1);

    // Reset in cycle 10 of a transaction.
    wait_ready();
    in_valid = 1'b1; in_dvdnd = 32'd1000; in_dvsr = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", 64'(in_ready), 64'(1));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_start", 64'(inpt_sgnl), 64'(0));
    check("midrst_dvdnd", 64'(dvdnd), 64'(0));
    check("midrst_dvsr", 64'(dvsr), 64'(0));
    check("midrst_dvdnd_len", 64'(dvdnd_len), 64'(0));
    check("midrst_dvsr_len", 64'(dvsr_len), 64'(0));
    do_pair(32'd9, 32'd1, 4, 1, 0, 1, 1'b0);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      in_dvdnd = $urandom >> $urandom_range(0, 32);
      in_dvsr  = ($urandom_range(0, 7) == 0) ? '0 : ($urandom >> $urandom_range(0, 31));
      done     = ($urandom_range(0, 2) != 0);
      rst      = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; done = 1'b1;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
